// File: rtl/key_note_pkg.sv
// Shared types for key_note_encoder: FSM states, event record, sizing check.
package key_note_pkg;

   // 15 keys at most, so notes 1..15 always fit in four bits
   localparam int KEY_NOTE_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_e;

   typedef struct packed {
      logic [KEY_NOTE_W-1:0] note;
      logic                  press;
   } key_ev_t;

   function automatic bit note_w_ok(input int num_keys, input int note_w);
      return (num_keys < (1 << note_w));
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key bit: two-flop synchronizer plus a stable-count filter.
// The filter exists only when KEY_NOTE_DEBOUNCE_EN is defined.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic d_out
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = d_in;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

`ifdef KEY_NOTE_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;

   // any agreement with the accepted level restarts the run
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = ~db_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         db_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         db_q  <= db_d;
      end
   end

   assign d_out = db_q;
`else
   assign d_out = sync2_q;
`endif

endmodule

// File: rtl/key_note_encoder.sv
// Keyboard-to-note encoder: debounced keys, press/release FSM, event FIFO.
// Define KEY_NOTE_DEBOUNCE_EN to enable per-key debounce filtering.
module key_note_encoder
   import key_note_pkg::*;
#(
   parameter int NUM_KEYS        = 7,
   parameter int NOTE_W          = 4,
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NOTE_W-1:0]   note_out,
   output logic                note_valid,
   output logic                ev_valid,
   input  logic                ev_ready,
   output logic [NOTE_W-1:0]   ev_note,
   output logic                ev_press
);

   if (NUM_KEYS < 2 || NUM_KEYS > 15) begin : g_bad_keys
      $error("key_note_encoder: NUM_KEYS must be 2..15");
   end
   if (!note_w_ok(NUM_KEYS, NOTE_W)) begin : g_bad_note_w
      $error("key_note_encoder: 2**NOTE_W must exceed NUM_KEYS");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("key_note_encoder: FIFO_DEPTH must be a power of two >= 2");
   end

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [NUM_KEYS-1:0] db_keys;
   logic [NOTE_W-1:0]   cur_note;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk  (clk),
         .rst_n(rst_n),
         .d_in (key_in[k]),
         .d_out(db_keys[k])
      );
   end

   // ascending scan, so the highest pressed index (lowest note) wins
   always_comb begin
      cur_note = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (db_keys[k]) begin
            cur_note = NOTE_W'(NUM_KEYS - k);
         end
      end
   end

   state_e            state_q, state_d;
   logic [NOTE_W-1:0] held_q, held_d;

   key_ev_t          mem_q [FIFO_DEPTH];
   key_ev_t          mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   logic    full;
   logic    pop;
   logic    push;
   logic    push_ok;
   key_ev_t push_ev;
   key_ev_t head;

   assign full    = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
   assign pop     = ev_valid && ev_ready;
   assign push_ok = !full || pop;

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      push    = 1'b0;
      push_ev = '0;
      unique case (state_q)
         IDLE: begin
            if (cur_note != '0 && push_ok) begin
               push          = 1'b1;
               push_ev.note  = KEY_NOTE_W'(cur_note);
               push_ev.press = 1'b1;
               held_d        = cur_note;
               state_d       = HELD;
            end
         end
         HELD: begin
            // release first; any new note is pressed from IDLE next cycle
            if (cur_note != held_q && push_ok) begin
               push          = 1'b1;
               push_ev.note  = KEY_NOTE_W'(held_q);
               push_ev.press = 1'b0;
               held_d        = '0;
               state_d       = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         held_q  <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_ev;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head       = mem_q[rd_ptr_q];
   assign ev_valid   = (count_q != '0);
   assign ev_note    = NOTE_W'(head.note);
   assign ev_press   = head.press;
   assign note_out   = held_q;
   assign note_valid = (held_q != '0);

endmodule

// File: tb/tb_key_note_encoder.sv
// Self-checking bench for key_note_encoder: directed scenarios plus
// random key/ready traffic against a behavioural reference model.
module tb_key_note_encoder;

   localparam int NK = 7;
   localparam int NW = 4;
   localparam int DB = 4;
   localparam int FD = 2;
`ifdef KEY_NOTE_DEBOUNCE_EN
   localparam int LAT = 2 + DB + 1;
`else
   localparam int LAT = 3;
`endif

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic [NK-1:0] key_in   = '0;
   logic          ev_ready = 1'b0;
   logic [NW-1:0] note_out;
   logic          note_valid;
   logic          ev_valid;
   logic [NW-1:0] ev_note;
   logic          ev_press;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [NW:0] got_q[$];
   int          got_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   key_note_encoder #(
      .NUM_KEYS       (NK),
      .NOTE_W         (NW),
      .DEBOUNCE_CYCLES(DB),
      .FIFO_DEPTH     (FD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .note_out  (note_out),
      .note_valid(note_valid),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_note   (ev_note),
      .ev_press  (ev_press)
   );

   // ---------------- reference model ----------------
   logic [NK-1:0] m_s1 = '0;
   logic [NK-1:0] m_s2 = '0;
   logic [NK-1:0] m_db = '0;
   logic [NK-1:0] m_hist[$];
   int            m_held = 0;
   logic [NW:0]   m_q[$];

   function automatic int low_note(input logic [NK-1:0] v);
      for (int k = NK - 1; k >= 0; k--) begin
         if (v[k]) return NK - k;
      end
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int cur;
      bit pop;
      bit allow;
      bit diff;
      if (!rst_n) begin
         m_s1   = '0;
         m_s2   = '0;
         m_db   = '0;
         m_held = 0;
         m_hist.delete();
         m_q.delete();
      end else begin
         cur   = low_note(m_db);
         pop   = (m_q.size() != 0) && ev_ready;
         allow = (m_q.size() < FD) || pop;
         if (pop) void'(m_q.pop_front());
         if (allow) begin
            if (m_held == 0 && cur != 0) begin
               m_q.push_back({NW'(cur), 1'b1});
               m_held = cur;
            end else if (m_held != 0 && cur != m_held) begin
               m_q.push_back({NW'(m_held), 1'b0});
               m_held = 0;
            end
         end
`ifdef KEY_NOTE_DEBOUNCE_EN
         // accept a level once the last DB synced samples all disagree
         m_hist.push_back(m_s2);
         if (m_hist.size() > DB) void'(m_hist.pop_front());
         if (m_hist.size() == DB) begin
            for (int k = 0; k < NK; k++) begin
               diff = 1'b1;
               foreach (m_hist[i]) begin
                  if (m_hist[i][k] == m_db[k]) diff = 1'b0;
               end
               if (diff) m_db[k] = ~m_db[k];
            end
         end
`else
         m_db = m_s1;
`endif
         m_s2 = m_s1;
         m_s1 = key_in;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic run_collect(input int n);
      repeat (n) begin
         if (ev_valid && ev_ready) begin
            got_q.push_back({ev_note, ev_press});
            got_cyc.push_back(cyc);
         end
         tick();
      end
   endtask

   task automatic do_reset();
      key_in   = '0;
      ev_ready = 1'b0;
      rst_n    = 1'b0;
      run(2);
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      key_in   = '1;
      ev_ready = 1'b0;
      rst_n    = 1'b0;
      run(3);
      n_cmp++;
      if (note_out !== '0) begin
         n_err++;
         $display("FAIL reset_note: got %0d want 0", note_out);
      end
      n_cmp++;
      if (note_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_nvalid: got %0b want 0", note_valid);
      end
      n_cmp++;
      if (ev_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_evvalid: got %0b want 0", ev_valid);
      end
   endtask

   task automatic test_press();
      do_reset();
      key_in[6] = 1'b1;
      run(LAT - 1);
      n_cmp++;
      if (note_out !== '0) begin
         n_err++;
         $display("FAIL press_early: got %0d want 0", note_out);
      end
      tick();
      n_cmp++;
      if (note_out !== NW'(1) || note_valid !== 1'b1) begin
         n_err++;
         $display("FAIL press_note: got %0d/%0b want 1/1", note_out, note_valid);
      end
      n_cmp++;
      if (ev_valid !== 1'b1 || ev_note !== NW'(1) || ev_press !== 1'b1) begin
         n_err++;
         $display("FAIL press_event: got v%0b n%0d p%0b want v1 n1 p1",
                  ev_valid, ev_note, ev_press);
      end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      n_cmp++;
      if (ev_valid !== 1'b0) begin
         n_err++;
         $display("FAIL press_single: got ev_valid %0b want 0", ev_valid);
      end
      key_in[6] = 1'b0;
      run(LAT - 1);
      n_cmp++;
      if (note_out !== NW'(1)) begin
         n_err++;
         $display("FAIL release_early: got %0d want 1", note_out);
      end
      tick();
      n_cmp++;
      if (note_out !== '0 || ev_valid !== 1'b1 || ev_note !== NW'(1) || ev_press !== 1'b0) begin
         n_err++;
         $display("FAIL release_event: got note %0d v%0b n%0d p%0b want 0 v1 n1 p0",
                  note_out, ev_valid, ev_note, ev_press);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      key_in[3] = 1'b1;
      run(3);
      key_in[3] = 1'b0;
`ifdef KEY_NOTE_DEBOUNCE_EN
      for (int i = 0; i < 2 * LAT; i++) begin
         tick();
         n_cmp++;
         if (note_out !== '0 || ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_quiet: cycle %0d note %0d ev_valid %0b want 0/0",
                     i, note_out, ev_valid);
         end
      end
`else
      // without filtering the short pulse is a genuine press and release
      run(12);
      n_cmp++;
      if (ev_valid !== 1'b1 || ev_note !== NW'(4) || ev_press !== 1'b1) begin
         n_err++;
         $display("FAIL glitch_press: got v%0b n%0d p%0b want v1 n4 p1",
                  ev_valid, ev_note, ev_press);
      end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      n_cmp++;
      if (ev_valid !== 1'b1 || ev_note !== NW'(4) || ev_press !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_release: got v%0b n%0d p%0b want v1 n4 p0",
                  ev_valid, ev_note, ev_press);
      end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      n_cmp++;
      if (ev_valid !== 1'b0 || note_out !== '0) begin
         n_err++;
         $display("FAIL glitch_drain: got v%0b note %0d want 0/0", ev_valid, note_out);
      end
`endif
   endtask

   task automatic test_chord();
      do_reset();
      got_q.delete();
      got_cyc.delete();
      ev_ready  = 1'b1;
      key_in[6] = 1'b1;
      run_collect(LAT + 2);
      key_in[2] = 1'b1;
      run_collect(LAT + 2);
      key_in[6] = 1'b0;
      run_collect(LAT + 3);
      n_cmp++;
      if (got_q.size() != 3) begin
         n_err++;
         $display("FAIL chord_count: got %0d events want 3", got_q.size());
      end else begin
         n_cmp++;
         if (got_q[0] !== {NW'(1), 1'b1} || got_q[1] !== {NW'(1), 1'b0}
             || got_q[2] !== {NW'(5), 1'b1}) begin
            n_err++;
            $display("FAIL chord_order: got %h %h %h want %h %h %h",
                     got_q[0], got_q[1], got_q[2], 5'h03, 5'h02, 5'h0b);
         end
         n_cmp++;
         if (got_cyc[2] - got_cyc[1] != 1) begin
            n_err++;
            $display("FAIL chord_adjacent: gap %0d want 1", got_cyc[2] - got_cyc[1]);
         end
      end
      n_cmp++;
      if (note_out !== NW'(5)) begin
         n_err++;
         $display("FAIL chord_note: got %0d want 5", note_out);
      end
   endtask

   task automatic test_stall();
      do_reset();
      key_in[6] = 1'b1;
      run(LAT + 1);
      key_in[6] = 1'b0;
      run(LAT + 1);
      key_in[4] = 1'b1;
      run(LAT + 4);
      n_cmp++;
      if (note_out !== '0 || note_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stall_note: got %0d/%0b want 0/0", note_out, note_valid);
      end
      n_cmp++;
      if (ev_valid !== 1'b1 || ev_note !== NW'(1) || ev_press !== 1'b1) begin
         n_err++;
         $display("FAIL stall_head: got v%0b n%0d p%0b want v1 n1 p1",
                  ev_valid, ev_note, ev_press);
      end
      // full FIFO: this cycle pops the head and pushes the stalled press
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      n_cmp++;
      if (note_out !== NW'(3)) begin
         n_err++;
         $display("FAIL stall_resume: got %0d want 3", note_out);
      end
      n_cmp++;
      if (ev_valid !== 1'b1 || ev_note !== NW'(1) || ev_press !== 1'b0) begin
         n_err++;
         $display("FAIL stall_head2: got v%0b n%0d p%0b want v1 n1 p0",
                  ev_valid, ev_note, ev_press);
      end
      got_q.delete();
      got_cyc.delete();
      ev_ready = 1'b1;
      run_collect(4);
      n_cmp++;
      if (got_q.size() != 2) begin
         n_err++;
         $display("FAIL stall_occupancy: got %0d events want 2", got_q.size());
      end else begin
         n_cmp++;
         if (got_q[0] !== {NW'(1), 1'b0} || got_q[1] !== {NW'(3), 1'b1}) begin
            n_err++;
            $display("FAIL stall_order: got %h %h want %h %h",
                     got_q[0], got_q[1], 5'h02, 5'h07);
         end
      end
      n_cmp++;
      if (ev_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stall_drain: got ev_valid %0b want 0", ev_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      key_in[6] = 1'b1;
      run(LAT + 1);
      n_cmp++;
      if (note_out !== NW'(1) || ev_valid !== 1'b1) begin
         n_err++;
         $display("FAIL mid_hold: got note %0d v%0b want 1/1", note_out, ev_valid);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (note_out !== '0 || note_valid !== 1'b0 || ev_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_async: got note %0d nv%0b v%0b want 0 0 0",
                  note_out, note_valid, ev_valid);
      end
      run(2);
      rst_n = 1'b1;
      run(LAT - 1);
      n_cmp++;
      if (note_out !== '0 || ev_valid !== 1'b0) begin
         n_err++;
         $display("FAIL mid_early: got note %0d v%0b want 0/0", note_out, ev_valid);
      end
      tick();
      n_cmp++;
      if (note_out !== NW'(1) || ev_valid !== 1'b1 || ev_note !== NW'(1) || ev_press !== 1'b1) begin
         n_err++;
         $display("FAIL mid_repress: got note %0d v%0b n%0d p%0b want 1 v1 n1 p1",
                  note_out, ev_valid, ev_note, ev_press);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            key_in = key_in ^ (NK'(1) << $urandom_range(0, NK - 1));
         end
         ev_ready = ($urandom_range(0, 3) != 0);
         tick();
         n_cmp++;
         if (note_out !== NW'(m_held) || note_valid !== (m_held != 0)) begin
            n_err++;
            $display("FAIL rand_note: cycle %0d got %0d/%0b want %0d", i, note_out,
                     note_valid, m_held);
         end
         n_cmp++;
         if (ev_valid !== (m_q.size() != 0)) begin
            n_err++;
            $display("FAIL rand_evvalid: cycle %0d got %0b want %0d", i, ev_valid,
                     m_q.size());
         end else if (m_q.size() != 0) begin
            n_cmp++;
            if ({ev_note, ev_press} !== m_q[0]) begin
               n_err++;
               $display("FAIL rand_head: cycle %0d got %h want %h", i,
                        {ev_note, ev_press}, m_q[0]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_chord();
      test_stall();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
